// File: rtl/pc_pkg.sv
// Shared definitions for the RISCBlade program-counter sequencer:
// mode encodings and default widths.
package pc_pkg;

    localparam int PC_MODE_W          = 3;
    localparam int PC_ADDR_WIDTH_DEF  = 16;

    typedef enum logic [PC_MODE_W-1:0] {
        PCM_INC    = 3'd0,
        PCM_BRANCH = 3'd1,
        PCM_JUMP   = 3'd2,
        PCM_CALL   = 3'd3,
        PCM_RET    = 3'd4
    } pc_mode_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular storage with a saturating occupancy count.
// A push when full overwrites the oldest entry, because the write pointer already points at it.
module ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    ptr_r;
    logic [PW:0]      count_r;
    logic [PW-1:0]    top_idx_s;

    assign top_idx_s = ptr_r - PW'(1'b1);
    assign top       = mem_r[top_idx_s];
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign full      = (count_r == FULL_CNT);
    assign overflow  = push & full;
    assign underflow = pop & ~push & empty;

    // Stack storage, pointer and count; push wins if both are requested.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ptr_r   <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push) begin
            mem_r[ptr_r] <= din;
            ptr_r        <= ptr_r + PW'(1'b1);
            if (!full) begin
                count_r <= count_r + (PW+1)'(1'b1);
            end
        end else if (pop && !empty) begin
            ptr_r   <= top_idx_s;
            count_r <= count_r - (PW+1)'(1'b1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with next-PC selection (inc/branch/jump/call/ret)
// and a sticky return-stack error flag.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH   = PC_ADDR_WIDTH_DEF,
    parameter int STEP         = 2,
    parameter int OFFSET_SHIFT = 1,
    parameter int RESET_VECTOR = 0,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  PC_EN,
    input  logic [PC_MODE_W-1:0]  PC_MODE,
    input  logic                  BR_TAKEN,
    input  logic [ADDR_WIDTH-1:0] BR_OFFSET,
    input  logic [ADDR_WIDTH-1:0] JUMP_TARGET,
    output logic [ADDR_WIDTH-1:0] PC_OUT,
    output logic [ADDR_WIDTH-1:0] PC_PLUS,
    output logic                  RAS_EMPTY,
    output logic                  RAS_FULL,
    output logic                  RAS_ERR
);

    pc_mode_e              mode_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_plus_s;
    logic [ADDR_WIDTH-1:0] br_target_s;
    logic [ADDR_WIDTH-1:0] next_pc_s;
    logic [ADDR_WIDTH-1:0] ras_top_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  ras_empty_s;
    logic                  ras_full_s;
    logic                  ovf_s;
    logic                  unf_s;
    logic                  ras_err_r;

    assign mode_s      = pc_mode_e'(PC_MODE);
    assign pc_plus_s   = pc_r + ADDR_WIDTH'(STEP);
    assign br_target_s = pc_r + (BR_OFFSET << OFFSET_SHIFT);
    // The stack sees no requests while stalled, so it holds with the PC.
    assign push_s      = PC_EN && (mode_s == PCM_CALL);
    assign pop_s       = PC_EN && (mode_s == PCM_RET);

    ras_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .push      (push_s),
        .pop       (pop_s),
        .din       (pc_plus_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s),
        .full      (ras_full_s),
        .overflow  (ovf_s),
        .underflow (unf_s)
    );

    // Next-PC selection; undefined modes fall through as sequential.
    always_comb begin
        next_pc_s = pc_plus_s;
        case (mode_s)
            PCM_INC:    next_pc_s = pc_plus_s;
            PCM_BRANCH: begin
                if (BR_TAKEN) next_pc_s = br_target_s;
                else          next_pc_s = pc_plus_s;
            end
            PCM_JUMP:   next_pc_s = JUMP_TARGET;
            PCM_CALL:   next_pc_s = JUMP_TARGET;
            PCM_RET: begin
                if (!ras_empty_s) next_pc_s = ras_top_s;
                else              next_pc_s = pc_plus_s;
            end
            default:    next_pc_s = pc_plus_s;
        endcase
    end

    // PC register and sticky stack-error flag.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            pc_r      <= ADDR_WIDTH'(RESET_VECTOR);
            ras_err_r <= 1'b0;
        end else if (PC_EN) begin
            pc_r      <= next_pc_s;
            ras_err_r <= ras_err_r | ovf_s | unf_s;
        end
    end

    assign PC_OUT    = pc_r;
    assign PC_PLUS   = pc_plus_s;
    assign RAS_EMPTY = ras_empty_s;
    assign RAS_FULL  = ras_full_s;
    assign RAS_ERR   = ras_err_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_pc_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        PC_EN = 1'b0;
    logic [2:0]  PC_MODE = 3'd0;
    logic        BR_TAKEN = 1'b0;
    logic [15:0] BR_OFFSET = 16'h0000;
    logic [15:0] JUMP_TARGET = 16'h0000;
    logic [15:0] PC_OUT;
    logic [15:0] PC_PLUS;
    logic        RAS_EMPTY;
    logic        RAS_FULL;
    logic        RAS_ERR;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference state: PC, stack as a queue (front = oldest), sticky error.
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_stk[$];
    logic        m_err = 1'b0;

    pc_sequencer dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .PC_EN       (PC_EN),
        .PC_MODE     (PC_MODE),
        .BR_TAKEN    (BR_TAKEN),
        .BR_OFFSET   (BR_OFFSET),
        .JUMP_TARGET (JUMP_TARGET),
        .PC_OUT      (PC_OUT),
        .PC_PLUS     (PC_PLUS),
        .RAS_EMPTY   (RAS_EMPTY),
        .RAS_FULL    (RAS_FULL),
        .RAS_ERR     (RAS_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        logic [15:0] exp_plus;
        exp_plus = m_pc + 16'd2;
        check_eq({tag, ".pc"},    {16'h0, PC_OUT},  {16'h0, m_pc});
        check_eq({tag, ".plus"},  {16'h0, PC_PLUS}, {16'h0, exp_plus});
        check_eq({tag, ".empty"}, {31'h0, RAS_EMPTY}, {31'h0, (m_stk.size() == 0)});
        check_eq({tag, ".full"},  {31'h0, RAS_FULL},  {31'h0, (m_stk.size() == 4)});
        check_eq({tag, ".err"},   {31'h0, RAS_ERR},   {31'h0, m_err});
    endtask

    // Asynchronous reset applied mid-cycle; checked before any clock edge.
    task automatic apply_reset();
        #2 RESET = 1'b1;
        #1;
        m_pc = 16'h0000;
        m_stk.delete();
        m_err = 1'b0;
        check_state("reset");
        #1 RESET = 1'b0;
    endtask

    task automatic model_update(input logic en, input logic [2:0] mode, input logic taken,
                                input logic [15:0] off, input logic [15:0] tgt);
        logic [15:0] link;
        link = m_pc + 16'd2;
        if (en) begin
            case (mode)
                3'd1: m_pc = taken ? m_pc + (off << 1) : link;
                3'd2: m_pc = tgt;
                3'd3: begin
                    if (m_stk.size() == 4) begin
                        void'(m_stk.pop_front());
                        m_err = 1'b1;
                    end
                    m_stk.push_back(link);
                    m_pc = tgt;
                end
                3'd4: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin
                        m_pc  = link;
                        m_err = 1'b1;
                    end
                end
                default: m_pc = link;
            endcase
        end
    endtask

    task automatic step(input logic en, input logic [2:0] mode, input logic taken,
                        input logic [15:0] off, input logic [15:0] tgt);
        PC_EN = en; PC_MODE = mode; BR_TAKEN = taken; BR_OFFSET = off; JUMP_TARGET = tgt;
        model_update(en, mode, taken, off, tgt);
        @(posedge CLOCK);
        #1;
        check_state("step");
    endtask

    initial begin
        @(posedge CLOCK); #1;
        apply_reset();

        // Reset and sequential increment, then a reset in the middle of a cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 1'b0, 16'h0, 16'h0);
        check_eq("inc3", {16'h0, PC_OUT}, 32'h0000_0006);
        apply_reset();
        check_eq("midrst", {16'h0, PC_OUT}, 32'h0000_0000);

        // Stall holds the PC despite a pending jump.
        step(1'b1, 3'd2, 1'b0, 16'h0, 16'h0010);
        for (int i = 0; i < 4; i++) step(1'b0, 3'd2, 1'b1, 16'h0, 16'h1234);
        check_eq("stall", {16'h0, PC_OUT}, 32'h0000_0010);

        // Branch taken/not taken and wrap-around.
        step(1'b1, 3'd2, 1'b0, 16'h0, 16'h0020);
        step(1'b1, 3'd1, 1'b1, 16'hFFFC, 16'h0);
        check_eq("br_taken", {16'h0, PC_OUT}, 32'h0000_0018);
        step(1'b1, 3'd2, 1'b0, 16'h0, 16'h0020);
        step(1'b1, 3'd1, 1'b0, 16'hFFFC, 16'h0);
        check_eq("br_not", {16'h0, PC_OUT}, 32'h0000_0022);
        step(1'b1, 3'd2, 1'b0, 16'h0, 16'hFFFE);
        step(1'b1, 3'd0, 1'b0, 16'h0, 16'h0);
        check_eq("wrap", {16'h0, PC_OUT}, 32'h0000_0000);

        // Nested call/return.
        apply_reset();
        step(1'b1, 3'd2, 1'b0, 16'h0, 16'h0100);
        step(1'b1, 3'd3, 1'b0, 16'h0, 16'h0200);
        check_eq("call1", {16'h0, PC_OUT}, 32'h0000_0200);
        step(1'b1, 3'd3, 1'b0, 16'h0, 16'h0300);
        check_eq("call2", {16'h0, PC_OUT}, 32'h0000_0300);
        step(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
        check_eq("ret1", {16'h0, PC_OUT}, 32'h0000_0202);
        step(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
        check_eq("ret2", {16'h0, PC_OUT}, 32'h0000_0102);
        check_eq("nest_empty", {31'h0, RAS_EMPTY}, 32'h1);
        check_eq("nest_err", {31'h0, RAS_ERR}, 32'h0);

        // Overflow: five calls, then four returns yield the newest links.
        apply_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 3'd3, 1'b0, 16'h0, 16'(i * 32'h1000));
        check_eq("ovf_full", {31'h0, RAS_FULL}, 32'h1);
        check_eq("ovf_err", {31'h0, RAS_ERR}, 32'h1);
        for (int i = 4; i >= 1; i--) begin
            step(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
            check_eq("ovf_ret", {16'h0, PC_OUT}, 32'(i * 32'h1000 + 32'h2));
        end
        check_eq("ovf_empty", {31'h0, RAS_EMPTY}, 32'h1);

        // Underflow sets the sticky error, which survives later increments.
        apply_reset();
        step(1'b1, 3'd4, 1'b0, 16'h0, 16'h0);
        check_eq("unf_pc", {16'h0, PC_OUT}, 32'h0000_0002);
        check_eq("unf_err", {31'h0, RAS_ERR}, 32'h1);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 1'b0, 16'h0, 16'h0);
        check_eq("unf_sticky", {31'h0, RAS_ERR}, 32'h1);

        // Randomized traffic, biased toward call/return, with occasional resets.
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            logic [2:0] md;
            if ($urandom_range(0, 99) < 2) apply_reset();
            md = ($urandom_range(0, 9) < 5) ? 3'($urandom_range(3, 4)) : 3'($urandom_range(0, 7));
            step(($urandom_range(0, 3) != 0), md, 1'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
